// File: rtl/router_sync_n_if.sv
// Handshake/bus bundle between the router FSM, register block, output FIFOs
// and router_sync_n. The slave modport is the synchroniser's view.
interface router_sync_n_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] read_enb;
  logic              timeout_en;
  logic [NUM_CH-1:0] sticky_clr;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;
  logic [NUM_CH-1:0] timeout_sticky;

  modport slave (
    input  detect_add, data_in, write_enb_reg, full, empty, read_enb,
           timeout_en, sticky_clr,
    output write_enb, fifo_full, vld_out, soft_reset, addr_err, timeout_sticky
  );

  modport master (
    output detect_add, data_in, write_enb_reg, full, empty, read_enb,
           timeout_en, sticky_clr,
    input  write_enb, fifo_full, vld_out, soft_reset, addr_err, timeout_sticky
  );
endinterface

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the packet address, steers write enable / full
// to the addressed FIFO, and runs a per-channel watchdog with sticky status.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic           clock,
  input  logic           resetn,
  router_sync_n_if.slave bus
);

  if (NUM_CH < 1 || NUM_CH > 2**ADDR_W || TIMEOUT < 2) begin : g_param_check
    $error("router_sync_n: illegal NUM_CH/ADDR_W/TIMEOUT combination");
  end

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    addr_d     = addr_q;
    addr_err_d = addr_err_q;
    if (bus.detect_add) begin
      addr_d     = bus.data_in;
      addr_err_d = (int'(bus.data_in) >= NUM_CH);
    end
  end

  // Decode uses the registered address, so a header cycle still steers to the
  // previous packet's channel.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!addr_err_q && addr_q == ADDR_W'(i)) begin
        write_enb[i] = bus.write_enb_reg;
        fifo_full    = bus.full[i];
      end
    end
  end

  always_comb begin
    soft_reset_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!bus.timeout_en || bus.empty[i] || bus.read_enb[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]        = '0;
        soft_reset_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // Set dominates clear when both land on the same edge.
    sticky_d = (sticky_q & ~bus.sticky_clr) | soft_reset_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the watchdog counters are a small register array, not RAM, so they
  // are cleared by the async reset like any other flop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q       <= '0;
      addr_err_q   <= 1'b0;
      soft_reset_q <= '0;
      sticky_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      addr_q       <= addr_d;
      addr_err_q   <= addr_err_d;
      soft_reset_q <= soft_reset_d;
      sticky_q     <= sticky_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.write_enb      = write_enb;
  assign bus.fifo_full      = fifo_full;
  assign bus.vld_out        = ~bus.empty;
  assign bus.soft_reset     = soft_reset_q;
  assign bus.addr_err       = addr_err_q;
  assign bus.timeout_sticky = sticky_q;

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n (NUM_CH=3, ADDR_W=2, TIMEOUT=30).
// Edge n is the n-th posedge after a scenario starts; outputs sampled 1ns after.
module tb_router_sync_n;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;

  logic clock;
  logic resetn;
  int   total;
  int   bad;
  int   cyc;
  int   q0[$];
  int   q1[$];
  int   q2[$];

  router_sync_n_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (bus.soft_reset[0]) q0.push_back(cyc);
    if (bus.soft_reset[1]) q1.push_back(cyc);
    if (bus.soft_reset[2]) q2.push_back(cyc);
  endtask

  task automatic start_log();
    cyc = 0;
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Empty all FIFOs, clear sticky flags, and let counters settle to zero.
  task automatic idle();
    bus.empty      = 3'b111;
    bus.read_enb   = 3'b000;
    bus.timeout_en = 1'b1;
    bus.sticky_clr = 3'b111;
    step();
    step();
    bus.sticky_clr = 3'b000;
  endtask

  task automatic test_reset();
    bus.detect_add    = 1'b0;
    bus.data_in       = '0;
    bus.write_enb_reg = 1'b1;
    bus.full          = 3'b001;
    bus.empty         = 3'b111;
    bus.read_enb      = 3'b000;
    bus.timeout_en    = 1'b1;
    bus.sticky_clr    = 3'b000;
    resetn            = 1'b0;
    #12;
    total++;
    if (bus.write_enb !== 3'b001) begin
      bad++; $display("FAIL reset_write_enb: got %b want 001", bus.write_enb);
    end
    total++;
    if (bus.fifo_full !== 1'b1) begin
      bad++; $display("FAIL reset_fifo_full: got %b want 1", bus.fifo_full);
    end
    total++;
    if ({bus.addr_err, bus.soft_reset, bus.timeout_sticky} !== 7'b0) begin
      bad++; $display("FAIL reset_regs: got %b want 0000000",
                      {bus.addr_err, bus.soft_reset, bus.timeout_sticky});
    end
    @(negedge clock);
    resetn = 1'b1;
    bus.write_enb_reg = 1'b0;
    bus.full          = 3'b000;
  endtask

  task automatic test_addr_latch();
    bus.write_enb_reg = 1'b1;
    bus.full          = 3'b100;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd2;
    #1;
    total++;
    if (bus.write_enb !== 3'b001 || bus.fifo_full !== 1'b0) begin
      bad++; $display("FAIL same_cycle_old_addr: got we=%b ff=%b want we=001 ff=0",
                      bus.write_enb, bus.fifo_full);
    end
    step();
    bus.detect_add = 1'b0;
    #1;
    total++;
    if (bus.write_enb !== 3'b100 || bus.fifo_full !== 1'b1 || bus.addr_err !== 1'b0) begin
      bad++; $display("FAIL addr2_decode: got we=%b ff=%b err=%b want 100/1/0",
                      bus.write_enb, bus.fifo_full, bus.addr_err);
    end
    bus.full       = 3'b111;
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd3;
    step();
    bus.detect_add = 1'b0;
    #1;
    total++;
    if (bus.write_enb !== 3'b000 || bus.fifo_full !== 1'b0 || bus.addr_err !== 1'b1) begin
      bad++; $display("FAIL addr3_invalid: got we=%b ff=%b err=%b want 000/0/1",
                      bus.write_enb, bus.fifo_full, bus.addr_err);
    end
    bus.full       = 3'b010;
    bus.detect_add = 1'b1;
    bus.data_in    = 2'd1;
    step();
    bus.detect_add = 1'b0;
    #1;
    total++;
    if (bus.write_enb !== 3'b010 || bus.fifo_full !== 1'b1 || bus.addr_err !== 1'b0) begin
      bad++; $display("FAIL addr1_recover: got we=%b ff=%b err=%b want 010/1/0",
                      bus.write_enb, bus.fifo_full, bus.addr_err);
    end
    bus.empty = 3'b010;
    #1;
    total++;
    if (bus.vld_out !== 3'b101) begin
      bad++; $display("FAIL vld_out: got %b want 101", bus.vld_out);
    end
    bus.write_enb_reg = 1'b0;
    bus.full          = 3'b000;
  endtask

  task automatic test_watchdog_basic();
    idle();
    bus.empty = 3'b110;
    start_log();
    repeat (62) begin
      step();
      if (cyc == 29) begin
        total++;
        if (bus.timeout_sticky[0] !== 1'b0) begin
          bad++; $display("FAIL sticky_before_pulse: got %b want 0", bus.timeout_sticky[0]);
        end
      end
      if (cyc == 30) begin
        total++;
        if (bus.timeout_sticky[0] !== 1'b1) begin
          bad++; $display("FAIL sticky_at_pulse: got %b want 1", bus.timeout_sticky[0]);
        end
      end
    end
    total++;
    if (q0.size() != 2 || q0[0] != 30 || q0[1] != 60) begin
      bad++; $display("FAIL ch0_pulses: got count=%0d first=%0d want 30,60",
                      q0.size(), (q0.size() > 0) ? q0[0] : -1);
    end
    total++;
    if (q1.size() != 0 || q2.size() != 0) begin
      bad++; $display("FAIL ch12_quiet: got %0d/%0d pulses want 0/0", q1.size(), q2.size());
    end
    total++;
    if (bus.timeout_sticky !== 3'b001) begin
      bad++; $display("FAIL sticky_end: got %b want 001", bus.timeout_sticky);
    end
  endtask

  task automatic test_read_restart();
    idle();
    bus.empty = 3'b101;
    start_log();
    repeat (62) begin
      step();
      bus.read_enb[1] = (cyc == 29);
    end
    total++;
    if (q1.size() != 1 || q1[0] != 60) begin
      bad++; $display("FAIL read_restart: got count=%0d first=%0d want one at 60",
                      q1.size(), (q1.size() > 0) ? q1[0] : -1);
    end
    idle();
    bus.empty = 3'b101;
    start_log();
    repeat (50) begin
      step();
      bus.empty[1] = (cyc == 15);
    end
    total++;
    if (q1.size() != 1 || q1[0] != 46) begin
      bad++; $display("FAIL empty_restart: got count=%0d first=%0d want one at 46",
                      q1.size(), (q1.size() > 0) ? q1[0] : -1);
    end
  endtask

  task automatic test_enable_and_sticky();
    idle();
    bus.empty = 3'b110;
    start_log();
    repeat (86) begin
      step();
      if (cyc == 20) bus.timeout_en = 1'b0;
      if (cyc == 25) bus.timeout_en = 1'b1;
      if (cyc == 84) bus.sticky_clr = 3'b001;
      if (cyc == 85) begin
        total++;
        if (bus.timeout_sticky[0] !== 1'b1) begin
          bad++; $display("FAIL sticky_set_wins: got %b want 1", bus.timeout_sticky[0]);
        end
      end
      if (cyc == 86) begin
        total++;
        if (bus.timeout_sticky[0] !== 1'b0) begin
          bad++; $display("FAIL sticky_clear: got %b want 0", bus.timeout_sticky[0]);
        end
        bus.sticky_clr = 3'b000;
      end
    end
    total++;
    if (q0.size() != 2 || q0[0] != 55 || q0[1] != 85) begin
      bad++; $display("FAIL enable_gap_pulses: got count=%0d first=%0d want 55,85",
                      q0.size(), (q0.size() > 0) ? q0[0] : -1);
    end
  endtask

  task automatic test_async_reset();
    idle();
    bus.write_enb_reg = 1'b1;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'd2;
    step();
    bus.detect_add = 1'b0;
    bus.empty      = 3'b011;
    start_log();
    repeat (30) step();
    total++;
    if (q2.size() != 1 || bus.soft_reset !== 3'b100 || bus.timeout_sticky !== 3'b100) begin
      bad++; $display("FAIL pre_reset_state: got count=%0d sr=%b st=%b want 1/100/100",
                      q2.size(), bus.soft_reset, bus.timeout_sticky);
    end
    total++;
    if (bus.write_enb !== 3'b100) begin
      bad++; $display("FAIL pre_reset_we: got %b want 100", bus.write_enb);
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (bus.write_enb !== 3'b001 || bus.soft_reset !== 3'b000 ||
        bus.timeout_sticky !== 3'b000 || bus.addr_err !== 1'b0) begin
      bad++; $display("FAIL async_reset: got we=%b sr=%b st=%b err=%b want 001/000/000/0",
                      bus.write_enb, bus.soft_reset, bus.timeout_sticky, bus.addr_err);
    end
    #1;
    resetn = 1'b1;
    start_log();
    repeat (31) step();
    total++;
    if (q2.size() != 1 || q2[0] != 30) begin
      bad++; $display("FAIL post_reset_count: got count=%0d first=%0d want one at 30",
                      q2.size(), (q2.size() > 0) ? q2[0] : -1);
    end
    bus.write_enb_reg = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_addr_latch();
    test_watchdog_basic();
    test_read_restart();
    test_enable_and_sticky();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised synchroniser between the router FSM, the register block and NUM_CH output FIFOs. It latches the destination address of each packet. It steers the write enable and the full flag to the addressed FIFO and drives a valid flag for each channel. It also runs a watchdog per channel that soft-resets any FIFO left unread too long. Compared with the 3-channel fixed version, it adds:
- invalid-address detection
- a runtime watchdog enable
- sticky timeout status flags

Parameters:
NUM_CH, 3, number of output channels/FIFOs; legal range 1..2**ADDR_W.
ADDR_W, 2, width of the address field in the header byte.
TIMEOUT, 30, number of consecutive valid-but-unread cycles before soft reset; must be >= 2.

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
detect_add  in  1  FSM strobe: header on data_in, latch address
data_in  in  ADDR_W  destination address field
write_enb_reg  in  1  FSM write request for current packet
full  in  NUM_CH  per-FIFO full flags
empty  in  NUM_CH  per-FIFO empty flags
read_enb  in  NUM_CH  per-channel read strobes from destination
timeout_en  in  1  global watchdog enable
sticky_clr  in  NUM_CH  per-channel clear of timeout_sticky
write_enb  out  NUM_CH  one-hot write enable to addressed FIFO
fifo_full  out  1  full flag of addressed FIFO
vld_out  out  NUM_CH  per-channel data valid
soft_reset  out  NUM_CH  per-channel one-cycle soft reset pulse
addr_err  out  1  latched address >= NUM_CH
timeout_sticky  out  NUM_CH  per-channel timeout has occurred

Behaviour:
- Reset (async, resetn=0): addr_q=0, addr_err=0, all cnt=0, soft_reset=0, timeout_sticky=0. The registers clear immediately, not at the next edge. Combinational outputs then decode addr_q=0.
- Address latch: on a posedge with detect_add=1, addr_q<=data_in and addr_err<=(data_in>=NUM_CH). Otherwise both hold.
  - Same-cycle rule: write_enb and fifo_full use the old addr_q during the detect_add cycle.
- write_enb (combinational): write_enb[addr_q]=write_enb_reg & ~addr_err; all other bits 0.
  - When addr_err=1, write_enb is all zeros and the packet is dropped by the FIFOs.
- fifo_full (combinational): full[addr_q] when addr_err=0, else 0. The FSM therefore never stalls on an invalid address.
- vld_out[i] = ~empty[i] (combinational, zero latency).
- Watchdog counter cnt[i], width $clog2(TIMEOUT). Each posedge:
  - If timeout_en=0, vld_out[i]=0 or read_enb[i]=1: cnt[i]<=0 and soft_reset[i]<=0. The counter clears rather than holds when the FIFO goes empty.
  - Else if cnt[i]==TIMEOUT-1: soft_reset[i]<=1 and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1 and soft_reset[i]<=0.
- Watchdog consequences:
  - soft_reset[i] rises on the TIMEOUT-th consecutive qualifying posedge and is high for exactly one cycle.
  - If the FIFO is still non-empty after the pulse, counting restarts from 0; the next pulse comes TIMEOUT cycles later.
  - A read_enb[i] pulse on any cycle restarts the count.
  - Deasserting timeout_en mid-count clears all counters.
- Channels are fully independent; simultaneous pulses on several channels are legal.
- timeout_sticky[i]:
  - Set on the posedge at which soft_reset[i] goes to 1.
  - Cleared by sticky_clr[i]=1 at a posedge.
  - If set and clear occur on the same edge, set wins.
- Elaboration:
  - NUM_CH>2**ADDR_W or TIMEOUT<2 must stop elaboration with an error.
  - With NUM_CH=3, ADDR_W=2, TIMEOUT=30 and timeout_en tied to 1, channel behaviour matches the 3-channel fixed version.
- No combinational path from any input to soft_reset or timeout_sticky.

Test Plan:
1. Defaults. detect_add=1 with data_in=2, then write_enb_reg=1 and full=3'b100 -> write_enb=3'b100 and fifo_full=1 from the next cycle. In the detect_add cycle itself, write_enb still decodes the previous address.
2. detect_add with data_in=3 (NUM_CH=3), write_enb_reg=1 -> addr_err=1, write_enb=000, fifo_full=0. Next detect_add with data_in=1 -> addr_err=0, write_enb=010.
3. empty[0]=0, read_enb[0]=0, timeout_en=1 held 60 cycles -> soft_reset[0] one-cycle pulse after the 30th and 60th posedges. timeout_sticky[0]=1 from the first pulse on. Channels 1 and 2 stay quiet.
4. Channel 1 valid, read_enb[1] pulsed at cycle 29 -> no soft_reset. Pulse occurs 30 cycles after the read. Same run with empty[1] going high at cycle 15 and low at 16 -> count restarts, no pulse before cycle 46.
5. timeout_en dropped at cycle 20 and restored at 25 -> pulse at cycle 55. sticky_clr[0] and a soft_reset set on the same edge -> sticky stays 1. sticky_clr alone -> 0.
6. resetn asserted asynchronously mid-count with addr_q=2 -> all registered outputs 0 and write_enb decodes channel 0 before the next clock edge. After release, the count starts from 0.
